// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: PWM configuration registers with a duty-cycle ramp engine.
// Owns the four enable bytes and the duty cycle. SPI register writes and an
// internal ramp engine share the duty cycle; a direct duty write always wins.
// Optional completion pulse: define PWM_RAMP_DONE_EN to build ramp_done,
// otherwise ramp_done is tied low.
module pwm_ramp_ctrl #(
    parameter int unsigned PRESCALE_SHIFT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       ramp_busy,
    output logic       ramp_done
);

    localparam int unsigned CntW = 8 + PRESCALE_SHIFT;

    typedef enum logic [1:0] {StIdle, StRampUp, StRampDown} state_e;

    state_e          state_q;
    logic [7:0]      en_out_lo_q, en_out_hi_q, en_pwm_lo_q, en_pwm_hi_q;
    logic [7:0]      duty_q, target_q, step_q, div_q;
    logic [CntW-1:0] cnt_q;

    logic [CntW:0]   term_wide;
    logic [CntW-1:0] term_cnt;
    logic [7:0]      step_eff, stepped;
    logic [8:0]      sum, diff;
    logic            tick, wr_duty, wr_target;

    // Tick detection and the clamped next duty value for the current direction.
    always_comb begin
        term_wide = ((CntW + 1)'(div_q) + (CntW + 1)'(1)) << PRESCALE_SHIFT;
        term_cnt  = CntW'(term_wide - (CntW + 1)'(1));
        tick      = (state_q != StIdle) && (cnt_q == term_cnt);
        step_eff  = (step_q == 8'd0) ? 8'd1 : step_q;
        sum       = {1'b0, duty_q} + {1'b0, step_eff};
        diff      = {1'b0, duty_q} - {1'b0, step_eff};
        // diff[8] flags a borrow, i.e. the step would wrap below 0x00
        if (state_q == StRampDown) begin
            stepped = (diff[8] || (diff[7:0] <= target_q)) ? target_q : diff[7:0];
        end else begin
            stepped = (sum > {1'b0, target_q}) ? target_q : sum[7:0];
        end
        wr_duty   = wr_valid && (wr_addr == 3'd4);
        wr_target = wr_valid && (wr_addr == 3'd5);
    end

    // Register file, tick counter and ramp FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            en_out_lo_q <= 8'h00;
            en_out_hi_q <= 8'h00;
            en_pwm_lo_q <= 8'h00;
            en_pwm_hi_q <= 8'h00;
            duty_q      <= 8'h00;
            target_q    <= 8'h00;
            step_q      <= 8'h01;
            div_q       <= 8'h00;
            cnt_q       <= '0;
        end else begin
            if (wr_valid) begin
                case (wr_addr)
                    3'd0:    en_out_lo_q <= wr_data;
                    3'd1:    en_out_hi_q <= wr_data;
                    3'd2:    en_pwm_lo_q <= wr_data;
                    3'd3:    en_pwm_hi_q <= wr_data;
                    3'd5:    target_q    <= wr_data;
                    3'd6:    step_q      <= wr_data;
                    3'd7:    div_q       <= wr_data;
                    default: ;
                endcase
            end
            // Direct duty write overrides any tick update in the same cycle
            if (wr_duty) begin
                duty_q  <= wr_data;
                state_q <= StIdle;
                cnt_q   <= '0;
            end else if (wr_target) begin
                cnt_q <= '0;
                if (wr_data > duty_q) begin
                    state_q <= StRampUp;
                end else if (wr_data < duty_q) begin
                    state_q <= StRampDown;
                end else begin
                    state_q <= StIdle;
                end
            end else if (state_q != StIdle) begin
                if (tick) begin
                    duty_q <= stepped;
                    cnt_q  <= '0;
                    if (stepped == target_q) begin
                        state_q <= StIdle;
                    end
                end else begin
                    // Free-running wrap lets a shrunk ramp_div take effect naturally
                    cnt_q <= cnt_q + CntW'(1);
                end
            end
        end
    end

`ifdef PWM_RAMP_DONE_EN
    logic complete;
    logic ramp_done_q;

    // Completion: equal-target write, or a tick that lands exactly on target.
    always_comb begin
        complete = 1'b0;
        if (wr_target) begin
            complete = (wr_data == duty_q);
        end else begin
            complete = tick && !wr_duty && (stepped == target_q);
        end
    end

    // One-cycle pulse aligned with the final duty update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ramp_done_q <= 1'b0;
        end else begin
            ramp_done_q <= complete;
        end
    end

    assign ramp_done = ramp_done_q;
`else
    assign ramp_done = 1'b0;
`endif

    assign en_reg_out_7_0  = en_out_lo_q;
    assign en_reg_out_15_8 = en_out_hi_q;
    assign en_reg_pwm_7_0  = en_pwm_lo_q;
    assign en_reg_pwm_15_8 = en_pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;
    assign ramp_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed bench for pwm_ramp_ctrl with PRESCALE_SHIFT = 2.
// With PWM_RAMP_DONE_EN defined, ramp_done is expected to pulse on completion;
// otherwise it is expected to stay low.
module tb_pwm_ramp_ctrl;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       ramp_busy;
    logic       ramp_done;

    int checks = 0;
    int errors = 0;

`ifdef PWM_RAMP_DONE_EN
    localparam logic [7:0] DoneExp = 8'd1;
`else
    localparam logic [7:0] DoneExp = 8'd0;
`endif

    pwm_ramp_ctrl #(
        .PRESCALE_SHIFT(2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_valid        (wr_valid),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .ramp_busy       (ramp_busy),
        .ramp_done       (ramp_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Single-cycle write; returns one time unit after the capturing edge.
    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 8'h00;
        #12;
        check("rst_duty", pwm_duty_cycle, 8'h00);
        check("rst_busy", {7'd0, ramp_busy}, 8'h00);
        check("rst_done", {7'd0, ramp_done}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Asynchronous reset in the middle of a ramp
        wr(3'd0, 8'h11);
        wr(3'd3, 8'h22);
        wr(3'd4, 8'h37);
        wr(3'd5, 8'h80);
        check("pre_rst_duty", pwm_duty_cycle, 8'h37);
        check("pre_rst_busy", {7'd0, ramp_busy}, 8'h01);
        check("pre_rst_en_out_lo", en_reg_out_7_0, 8'h11);
        step(1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_duty", pwm_duty_cycle, 8'h00);
        check("async_rst_busy", {7'd0, ramp_busy}, 8'h00);
        check("async_rst_en_out_lo", en_reg_out_7_0, 8'h00);
        check("async_rst_en_pwm_hi", en_reg_pwm_15_8, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Enable byte write touches only its own register
        wr(3'd2, 8'hA5);
        check("en_pwm_lo", en_reg_pwm_7_0, 8'hA5);
        check("en_out_lo_untouched", en_reg_out_7_0, 8'h00);
        check("en_out_hi_untouched", en_reg_out_15_8, 8'h00);
        check("en_pwm_hi_untouched", en_reg_pwm_15_8, 8'h00);
        check("duty_untouched", pwm_duty_cycle, 8'h00);

        // Up ramp 0 -> 0x40 in 0x10 steps, one tick every 4 cycles
        wr(3'd6, 8'h10);
        wr(3'd5, 8'h40);
        check("up_start_busy", {7'd0, ramp_busy}, 8'h01);
        check("up_start_duty", pwm_duty_cycle, 8'h00);
        step(4);
        check("up_tick1", pwm_duty_cycle, 8'h10);
        step(3);
        check("up_hold", pwm_duty_cycle, 8'h10);
        step(1);
        check("up_tick2", pwm_duty_cycle, 8'h20);
        step(4);
        check("up_tick3", pwm_duty_cycle, 8'h30);
        step(3);
        check("up_pre_done", {7'd0, ramp_done}, 8'h00);
        check("up_pre_busy", {7'd0, ramp_busy}, 8'h01);
        step(1);
        check("up_tick4", pwm_duty_cycle, 8'h40);
        check("up_end_busy", {7'd0, ramp_busy}, 8'h00);
        check("up_end_done", {7'd0, ramp_done}, DoneExp);
        step(1);
        check("up_done_pulse_len", {7'd0, ramp_done}, 8'h00);

        // Clamp at the top, no wrap past 0xFF
        wr(3'd4, 8'hF0);
        wr(3'd6, 8'h20);
        wr(3'd5, 8'hFF);
        step(4);
        check("clamp_hi_duty", pwm_duty_cycle, 8'hFF);
        check("clamp_hi_busy", {7'd0, ramp_busy}, 8'h00);
        check("clamp_hi_done", {7'd0, ramp_done}, DoneExp);

        // Clamp at the bottom, no wrap past 0x00
        wr(3'd4, 8'h05);
        wr(3'd6, 8'h10);
        wr(3'd5, 8'h00);
        step(4);
        check("clamp_lo_duty", pwm_duty_cycle, 8'h00);
        check("clamp_lo_busy", {7'd0, ramp_busy}, 8'h00);

        // Direct duty write on the tick cycle aborts the ramp
        wr(3'd5, 8'h40);
        step(3);
        wr(3'd4, 8'h80);
        check("abort_duty", pwm_duty_cycle, 8'h80);
        check("abort_busy", {7'd0, ramp_busy}, 8'h00);
        check("abort_done", {7'd0, ramp_done}, 8'h00);
        step(4);
        check("abort_hold", pwm_duty_cycle, 8'h80);

        // Retarget downward mid-ramp
        wr(3'd4, 8'h00);
        wr(3'd5, 8'h40);
        step(8);
        check("retgt_mid_duty", pwm_duty_cycle, 8'h20);
        wr(3'd5, 8'h10);
        check("retgt_busy", {7'd0, ramp_busy}, 8'h01);
        check("retgt_duty_hold", pwm_duty_cycle, 8'h20);
        step(4);
        check("retgt_down_duty", pwm_duty_cycle, 8'h10);
        check("retgt_down_busy", {7'd0, ramp_busy}, 8'h00);
        check("retgt_down_done", {7'd0, ramp_done}, DoneExp);

        // Target equal to duty completes immediately without ramping
        wr(3'd5, 8'h10);
        check("equal_busy", {7'd0, ramp_busy}, 8'h00);
        check("equal_done", {7'd0, ramp_done}, DoneExp);
        check("equal_duty", pwm_duty_cycle, 8'h10);
        step(1);
        check("equal_done_clear", {7'd0, ramp_done}, 8'h00);

        // Step of zero behaves as one
        wr(3'd6, 8'h00);
        wr(3'd5, 8'h12);
        step(4);
        check("step0_tick1", pwm_duty_cycle, 8'h11);
        step(4);
        check("step0_tick2", pwm_duty_cycle, 8'h12);
        check("step0_busy", {7'd0, ramp_busy}, 8'h00);

        // ramp_div = 1 doubles the tick interval to 8 cycles
        wr(3'd7, 8'h01);
        wr(3'd6, 8'h10);
        wr(3'd5, 8'h32);
        step(7);
        check("div1_hold", pwm_duty_cycle, 8'h12);
        step(1);
        check("div1_tick1", pwm_duty_cycle, 8'h22);
        step(8);
        check("div1_tick2", pwm_duty_cycle, 8'h32);
        check("div1_busy", {7'd0, ramp_busy}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Configuration controller for the PWM peripheral. It owns the five PWM config registers: four output/PWM enable bytes and the duty cycle.
- Two requesters share the duty-cycle register:
  - register writes from the SPI peripheral's decoder;
  - an internal ramp engine that steps the duty cycle toward a target at a programmed rate.
- Sits between the SPI peripheral and the PWM peripheral. Its outputs drive the PWM peripheral's config inputs directly.

Parameters:
- PRESCALE_SHIFT, 8, ramp tick interval = (ramp_div+1) << PRESCALE_SHIFT clock cycles.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_valid  input  1  single-cycle write strobe from the SPI decoder.
- wr_addr  input  3  register address.
- wr_data  input  8  write data.
- en_reg_out_7_0  output  8  output enable, bits 7:0.
- en_reg_out_15_8  output  8  output enable, bits 15:8.
- en_reg_pwm_7_0  output  8  PWM mode enable, bits 7:0.
- en_reg_pwm_15_8  output  8  PWM mode enable, bits 15:8.
- pwm_duty_cycle  output  8  current duty cycle.
- ramp_busy  output  1  high while the ramp engine is active.
- ramp_done  output  1  one-cycle completion pulse (see Optional Feature).

Behaviour:
- Register map (write-only, no read path):
  - 0: en_reg_out_7_0
  - 1: en_reg_out_15_8
  - 2: en_reg_pwm_7_0
  - 3: en_reg_pwm_15_8
  - 4: duty (direct)
  - 5: ramp_target (write starts ramp)
  - 6: ramp_step
  - 7: ramp_div
- Reset values:
  - all outputs 0;
  - ramp_target 0, ramp_step 1, ramp_div 0;
  - tick counter 0, FSM IDLE.
- Reset is asynchronous, so it takes effect mid-ramp without waiting for a clock edge.
- Write latency: a write is visible on outputs the cycle after the wr_valid edge. Writes are always accepted; there is no backpressure.
- ramp_step = 0 is treated as 1.
- Tick counter: width 8+PRESCALE_SHIFT bits. Terminal count = ((ramp_div+1) << PRESCALE_SHIFT) - 1.
- FSM states: IDLE, RAMP_UP, RAMP_DOWN.
  - IDLE, write to addr 5:
    - target > duty → RAMP_UP;
    - target < duty → RAMP_DOWN;
    - target == duty → stay IDLE and assert ramp_done.
    - Entering a ramp clears the counter.
  - RAMP_UP / RAMP_DOWN:
    - The counter increments every cycle.
    - At terminal count: duty moves by ramp_step toward target and the counter clears.
    - Arithmetic is 9-bit and the result is clamped to target, so duty never overshoots and never wraps past 0x00/0xFF.
    - When duty equals target after an update → IDLE and assert ramp_done in the same cycle as the final update.
  - Write to addr 5 while ramping: retarget.
    - Counter clears; direction is recomputed from the current duty.
    - Equal target → IDLE with ramp_done.
  - Write to addr 4 while ramping: duty = wr_data, FSM → IDLE, no ramp_done.
- Simultaneous events:
  - A write to addr 4 in the same cycle as a tick update: the SPI value wins and the ramp aborts.
  - Writes to addrs 6/7 during a ramp: used from the next cycle. A ramp_div decrease below the current count takes effect when the counter wraps at its full width; the counter is not clamped.
  - Writes to addrs 0–3 never affect the ramp.
- ramp_busy = (state != IDLE), combinational from state.

Optional Feature:
- Macro: PWM_RAMP_DONE_EN.
- Defined: ramp_done pulses high for exactly one cycle on each completion, as described above.
- Undefined: ramp_done is tied to 0 and no completion logic is built. All other behaviour is identical.

Test Plan:
- Reset: assert rst mid-operation with duty=0x37 → all outputs 0, ramp_busy 0 immediately, without waiting for clk.
- Enable write: wr_addr=2, wr_data=0xA5 → en_reg_pwm_7_0=0xA5 next cycle; other outputs unchanged.
- Up ramp: PRESCALE_SHIFT=2, div=0, step=0x10, duty=0, write target 0x40 → duty 0x10/0x20/0x30/0x40 every 4 cycles; busy drops and ramp_done pulses with the 0x40 update.
- Clamp: duty=0xF0, step=0x20, target=0xFF → 0xFF after one tick (no wrap). Separately: duty=0x05, step=0x10, target=0x00 → 0x00 after one tick.
- Abort collision: mid up-ramp, write addr 4 = 0x80 on the tick cycle → duty=0x80, busy 0, no ramp_done.
- Retarget/equal: mid-ramp at duty 0x20, write target 0x10 → switches to RAMP_DOWN. Write target equal to duty → ramp_done pulses, busy stays 0. With macro undefined, ramp_done stays 0 throughout.
